// File: rtl/rr_grant_ctrl_pkg.sv
// rtl/rr_grant_ctrl_pkg.sv - shared types and helpers for the round-robin grant controller
package rr_grant_ctrl_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// rtl/rr_grant_ctrl_if.sv - request/grant bundle between requesters and the arbiter
interface rr_grant_ctrl_if #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
);
  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [IW-1:0]    gnt_id;
  logic [HW-1:0]    hold_cnt;

  modport master (output req, input gnt, gnt_valid, gnt_id, hold_cnt);
  modport slave  (input req, output gnt, gnt_valid, gnt_id, hold_cnt);
endinterface

// File: rtl/rr_grant_ctrl_prio_pick.sv
// rtl/rr_grant_ctrl_prio_pick.sv - rotated priority encoder: first set req at or after ptr, with wrap
module rr_prio_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic             o_found,
  output logic [IW-1:0]    o_idx
);
  int         w_j;
  logic [IW-1:0] w_pos;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    w_pos   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      w_pos = IW'(w_j);
      if (i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end
endmodule

// File: rtl/rr_grant_ctrl.sv
// rtl/rr_grant_ctrl.sv - round-robin arbiter with registered one-hot grant, hold limit and release gap
module rr_grant_ctrl
  import rr_grant_ctrl_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input logic          clk,
  input logic          rst,
  rr_grant_ctrl_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t       r_state, w_state_n;
  logic [IW-1:0]    r_ptr, w_ptr_n;
  logic [N_REQ-1:0] r_gnt, w_gnt_n;
  logic             r_gnt_valid;
  logic [IW-1:0]    r_gnt_id, w_gnt_id_n;
  logic [HW-1:0]    r_hold, w_hold_n;
  logic             w_found;
  logic [IW-1:0]    w_pick;

  rr_prio_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_n;
      r_ptr       <= w_ptr_n;
      r_gnt       <= w_gnt_n;
      r_gnt_valid <= |w_gnt_n;
      r_gnt_id    <= w_gnt_id_n;
      r_hold      <= w_hold_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_ptr_n    = r_ptr;
    w_gnt_n    = r_gnt;
    w_gnt_id_n = r_gnt_id;
    w_hold_n   = r_hold;
    case (r_state)
      GRANT: begin
        if (bus.req[r_gnt_id] && (r_hold < HW'(MAX_HOLD))) begin
          w_hold_n = r_hold + HW'(1);
        end else begin
          w_state_n  = RELEASE;
          w_gnt_n    = '0;
          w_gnt_id_n = '0;
          w_hold_n   = '0;
          w_ptr_n    = (r_gnt_id == IW'(N_REQ - 1)) ? '0 : r_gnt_id + IW'(1);
        end
      end
      default: begin
        // IDLE and RELEASE both arbitrate; RELEASE itself already provided the gap cycle.
        w_gnt_n    = '0;
        w_gnt_id_n = '0;
        w_hold_n   = '0;
        w_state_n  = IDLE;
        if (w_found) begin
          w_state_n  = GRANT;
          w_gnt_n    = N_REQ'(1) << w_pick;
          w_gnt_id_n = w_pick;
          w_hold_n   = HW'(1);
        end
      end
    endcase
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.hold_cnt  = r_hold;

  a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));
  a_req_before_gnt : assert property (@(posedge clk) disable iff (rst)
    (bus.gnt & ~$past(bus.req)) == '0);
  // A grant can only move to another owner through a zero cycle.
  a_no_back_to_back : assert property (@(posedge clk) disable iff (rst)
    (bus.gnt_valid && $past(bus.gnt_valid)) |-> $stable(bus.gnt));
  a_id_matches : assert property (@(posedge clk) disable iff (rst)
    bus.gnt_valid |-> (4'(bus.gnt_id) == onehot_to_idx(MAX_REQ'(bus.gnt))));
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb/tb_rr_grant_ctrl.sv - directed self-checking bench for rr_grant_ctrl
module tb_rr_grant_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_grant_ctrl_if #(.N_REQ(4), .MAX_HOLD(8)) bus ();

  rr_grant_ctrl #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] exp_gnt, input int exp_hold);
    logic [1:0] exp_id;
    exp_id = 2'd0;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) exp_id = 2'(i);
    chk({tag, "_gnt"},   32'(bus.gnt),       32'(exp_gnt));
    chk({tag, "_valid"}, 32'(bus.gnt_valid), 32'(|exp_gnt));
    chk({tag, "_id"},    32'(bus.gnt_id),    32'(exp_id));
    chk({tag, "_hold"},  32'(bus.hold_cnt),  32'(exp_hold));
  endtask

  initial begin
    logic [3:0] g;
    int order [5];
    checks  = 0;
    errors  = 0;
    order   = '{0, 1, 2, 3, 0};
    rst     = 1'b1;
    bus.req = 4'b1111;
    tick();
    tick();
    chk_grant("reset", 4'b0000, 0);

    // 1: first grant one clock after request
    rst     = 1'b0;
    bus.req = 4'b0001;
    tick();
    chk_grant("first_gnt", 4'b0001, 1);
    bus.req = 4'b0000;
    tick();
    chk_grant("first_rel", 4'b0000, 0);

    // async reset clears ptr (was 1) without a clock edge
    rst = 1'b1;
    #1;
    chk_grant("async_rst_idle", 4'b0000, 0);
    tick();
    rst = 1'b0;

    // 2: full round robin, each owner for MAX_HOLD cycles plus one gap
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      g = 4'b0001 << order[n];
      for (int c = 1; c <= 8; c++) begin
        tick();
        chk_grant($sformatf("rr%0d_c%0d", n, c), g, c);
      end
      tick();
      chk_grant($sformatf("rr%0d_gap", n), 4'b0000, 0);
    end

    // 3: owner 2 releases early after 3 cycles, ptr then 3
    bus.req = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk_grant($sformatf("early_c%0d", c), 4'b0100, c);
    end
    bus.req = 4'b1000;
    tick();
    chk_grant("early_gap", 4'b0000, 0);
    tick();
    chk_grant("early_next", 4'b1000, 1);

    // 5: owner 3 releases, ptr wraps to 0
    bus.req = 4'b0011;
    tick();
    chk_grant("wrap_gap", 4'b0000, 0);
    tick();
    chk_grant("wrap_next", 4'b0001, 1);

    // 4: sole requester 2 is re-granted after every hold expiry
    bus.req = 4'b0100;
    tick();
    chk_grant("sole_gap0", 4'b0000, 0);
    tick();
    chk_grant("sole_g0_c1", 4'b0100, 1);
    for (int r = 0; r < 2; r++) begin
      for (int c = 2; c <= 8; c++) begin
        tick();
        chk_grant($sformatf("sole_g%0d_c%0d", r, c), 4'b0100, c);
      end
      tick();
      chk_grant($sformatf("sole_gap%0d", r + 1), 4'b0000, 0);
      tick();
      chk_grant($sformatf("sole_g%0d_c1", r + 1), 4'b0100, 1);
    end

    // 6: async reset mid-grant at hold_cnt=5; ptr (3) must return to 0
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk_grant($sformatf("mid_c%0d", c), 4'b0100, c);
    end
    #2;
    rst = 1'b1;
    #1;
    chk_grant("mid_rst", 4'b0000, 0);
    bus.req = 4'b1001;
    #1;
    rst = 1'b0;
    tick();
    chk_grant("post_rst", 4'b0001, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
